// File: rtl/rv_pkg.sv
// rv_pkg: shared RV32 decode definitions for the decode stage.
//   - base opcode values (full 7-bit field, including the 2'b11 length bits)
//   - immediate-format enum used by imm_gen
//   - instruction field bit positions
//   - small decode helpers: immediate format, opcode legality, rd write
package rv_pkg;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  // Field positions inside the 32-bit instruction word.
  localparam int OPC_MSB    = 6;
  localparam int RD_LSB     = 7;
  localparam int FUNCT3_LSB = 12;
  localparam int RS1_LSB    = 15;
  localparam int RS2_LSB    = 20;
  localparam int ALT_BIT    = 30;

  function automatic imm_type_e imm_type_of(input logic [6:0] opc);
    imm_type_e t;
    t = IMM_NONE;
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: t = IMM_I;
      OPC_STORE:                      t = IMM_S;
      OPC_BRANCH:                     t = IMM_B;
      OPC_LUI, OPC_AUIPC:             t = IMM_U;
      OPC_JAL:                        t = IMM_J;
      default:                        t = IMM_NONE;
    endcase
    return t;
  endfunction

  function automatic logic is_legal_opcode(input logic [6:0] opc);
    logic ok;
    ok = 1'b0;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
      OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic writes_rd(input logic [6:0] opc);
    logic we;
    we = 1'b0;
    case (opc)
      OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
      OPC_AUIPC, OPC_JAL, OPC_JALR: we = 1'b1;
      default: we = 1'b0;
    endcase
    return we;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: combinational immediate generator.
//   instr    [31:7] instruction word above the opcode field
//   imm_type        immediate format selected by the decoder
//   imm      [W:0]  sign-extended immediate (0 for IMM_NONE)
module imm_gen
  import rv_pkg::*;
#(
  parameter int W = 31
) (
  input  logic [31:7] instr,
  input  imm_type_e   imm_type,
  output logic [W:0]  imm
);

  logic signed [31:0] imm32;

  // NOTE: every combinational output gets a default before the case so that
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    imm32 = '0;
    case (imm_type)
      IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U: imm32 = {instr[31:12], 12'b0};
      IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  // Size cast of a signed value sign-extends (or truncates) to the datapath.
  assign imm = (W+1)'(imm32);

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction decode stage.
//   clk, nrst                    clock, synchronous active-low reset
//   in_valid/in_ready/in_instr/in_pc   fetch handshake and instruction
//   radd1/radd2                  register-file read addresses
//   rs1/rs2                      register-file read data (one-cycle latency)
//   wb_wen/wb_wadd/wb_wdata      write-back snoop for operand bypass
//   flush                        kill the held bundle / discard an accept
//   ex_ready                     EX consumes the bundle
//   out_*                        decoded bundle presented to EX
module id_stage
  import rv_pkg::*;
#(
  parameter int         W        = 31,
  parameter logic [W:0] RESET_PC = '0
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_instr,
  input  logic [W:0]   in_pc,
  output logic [4:0]   radd1,
  output logic [4:0]   radd2,
  input  logic [W:0]   rs1,
  input  logic [W:0]   rs2,
  input  logic         wb_wen,
  input  logic [4:0]   wb_wadd,
  input  logic [W:0]   wb_wdata,
  input  logic         flush,
  input  logic         ex_ready,
  output logic         out_valid,
  output logic [W:0]   out_pc,
  output logic [W:0]   out_rs1_data,
  output logic [W:0]   out_rs2_data,
  output logic [W:0]   out_imm,
  output logic [4:0]   out_rd,
  output logic         out_rd_we,
  output logic [6:0]   out_opcode,
  output logic [2:0]   out_funct3,
  output logic         out_alt,
  output logic         out_illegal
);

  // Bundle registers
  logic         out_valid_q,   out_valid_d;
  logic [W:0]   out_pc_q,      out_pc_d;
  logic [W:0]   out_imm_q,     out_imm_d;
  logic [4:0]   out_rd_q,      out_rd_d;
  logic         out_rd_we_q,   out_rd_we_d;
  logic [6:0]   out_opcode_q,  out_opcode_d;
  logic [2:0]   out_funct3_q,  out_funct3_d;
  logic         out_alt_q,     out_alt_d;
  logic         out_illegal_q, out_illegal_d;
  logic [4:0]   rs1_addr_q,    rs1_addr_d;
  logic [4:0]   rs2_addr_q,    rs2_addr_d;

  // Last cycle's write-back, covering the write that lands on the same edge
  // as the register-file read.
  logic         wb_wen_q,   wb_wen_d;
  logic [4:0]   wb_wadd_q,  wb_wadd_d;
  logic [W:0]   wb_wdata_q, wb_wdata_d;

  // Decode of the incoming instruction
  logic [6:0]   dec_opcode;
  logic [4:0]   dec_rd;
  imm_type_e    dec_imm_type;
  logic         dec_illegal;
  logic         dec_rd_we;
  logic [W:0]   dec_imm;
  logic         accept;

  assign dec_opcode   = in_instr[OPC_MSB:0];
  assign dec_rd       = in_instr[RD_LSB +: 5];
  assign dec_imm_type = imm_type_of(dec_opcode);
  // The opcode table already contains the 2'b11 length bits; the explicit
  // test keeps the compressed-encoding rejection visible.
  assign dec_illegal  = !is_legal_opcode(dec_opcode) || (in_instr[1:0] != 2'b11);
  assign dec_rd_we    = writes_rd(dec_opcode) && (dec_rd != 5'd0) && !dec_illegal;

  imm_gen #(.W(W)) u_imm_gen (
    .instr    (in_instr[31:7]),
    .imm_type (dec_imm_type),
    .imm      (dec_imm)
  );

  assign in_ready = !out_valid_q || ex_ready;
  assign accept   = in_valid && in_ready;

  // While stalled the held addresses are re-read every cycle so the
  // registered read data tracks writes to the held operands.
  assign radd1 = in_ready ? in_instr[RS1_LSB +: 5] : rs1_addr_q;
  assign radd2 = in_ready ? in_instr[RS2_LSB +: 5] : rs2_addr_q;

  function automatic logic [W:0] bypass(
    input logic [4:0] addr,
    input logic [W:0] rf_data,
    input logic       wen_now,
    input logic [4:0] wadd_now,
    input logic [W:0] wdata_now,
    input logic       wen_prev,
    input logic [4:0] wadd_prev,
    input logic [W:0] wdata_prev
  );
    logic [W:0] v;
    if (addr == 5'd0)                           v = '0;
    else if (wen_now  && (wadd_now  == addr))   v = wdata_now;
    else if (wen_prev && (wadd_prev == addr))   v = wdata_prev;
    else                                        v = rf_data;
    return v;
  endfunction

  assign out_rs1_data = bypass(rs1_addr_q, rs1, wb_wen, wb_wadd, wb_wdata,
                               wb_wen_q, wb_wadd_q, wb_wdata_q);
  assign out_rs2_data = bypass(rs2_addr_q, rs2, wb_wen, wb_wadd, wb_wdata,
                               wb_wen_q, wb_wadd_q, wb_wdata_q);

  always_comb begin
    out_valid_d   = out_valid_q;
    out_pc_d      = out_pc_q;
    out_imm_d     = out_imm_q;
    out_rd_d      = out_rd_q;
    out_rd_we_d   = out_rd_we_q;
    out_opcode_d  = out_opcode_q;
    out_funct3_d  = out_funct3_q;
    out_alt_d     = out_alt_q;
    out_illegal_d = out_illegal_q;
    rs1_addr_d    = rs1_addr_q;
    rs2_addr_d    = rs2_addr_q;
    wb_wen_d      = wb_wen;
    wb_wadd_d     = wb_wadd;
    wb_wdata_d    = wb_wdata;

    // flush wins over both a new accept and a stall.
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d   = 1'b1;
      out_pc_d      = in_pc;
      out_imm_d     = dec_imm;
      out_rd_d      = dec_rd;
      out_rd_we_d   = dec_rd_we;
      out_opcode_d  = dec_opcode;
      out_funct3_d  = in_instr[FUNCT3_LSB +: 3];
      out_alt_d     = in_instr[ALT_BIT];
      out_illegal_d = dec_illegal;
      rs1_addr_d    = in_instr[RS1_LSB +: 5];
      rs2_addr_d    = in_instr[RS2_LSB +: 5];
    end else if (ex_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its pre-edge value; reset is synchronous, so it lives inside the clocked
  // branch rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      out_valid_q   <= 1'b0;
      out_pc_q      <= RESET_PC;
      out_imm_q     <= '0;
      out_rd_q      <= '0;
      out_rd_we_q   <= 1'b0;
      out_opcode_q  <= '0;
      out_funct3_q  <= '0;
      out_alt_q     <= 1'b0;
      out_illegal_q <= 1'b0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      wb_wen_q      <= 1'b0;
      wb_wadd_q     <= '0;
      wb_wdata_q    <= '0;
    end else begin
      out_valid_q   <= out_valid_d;
      out_pc_q      <= out_pc_d;
      out_imm_q     <= out_imm_d;
      out_rd_q      <= out_rd_d;
      out_rd_we_q   <= out_rd_we_d;
      out_opcode_q  <= out_opcode_d;
      out_funct3_q  <= out_funct3_d;
      out_alt_q     <= out_alt_d;
      out_illegal_q <= out_illegal_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      wb_wen_q      <= wb_wen_d;
      wb_wadd_q     <= wb_wadd_d;
      wb_wdata_q    <= wb_wdata_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_pc      = out_pc_q;
  assign out_imm     = out_imm_q;
  assign out_rd      = out_rd_q;
  assign out_rd_we   = out_rd_we_q;
  assign out_opcode  = out_opcode_q;
  assign out_funct3  = out_funct3_q;
  assign out_alt     = out_alt_q;
  assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed, table-driven bench for id_stage with a simple
// registered-read register-file model (it also stores writes to x0, so the
// stage's own x0 handling is what keeps x0 reading as zero).
module tb_id_stage;

  localparam int         W        = 31;
  localparam logic [W:0] RESET_PC = 32'h0000_0080;

  logic         clk;
  logic         nrst;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_instr;
  logic [W:0]   in_pc;
  logic [4:0]   radd1, radd2;
  logic [W:0]   rs1, rs2;
  logic         wb_wen;
  logic [4:0]   wb_wadd;
  logic [W:0]   wb_wdata;
  logic         flush;
  logic         ex_ready;
  logic         out_valid;
  logic [W:0]   out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [4:0]   out_rd;
  logic         out_rd_we;
  logic [6:0]   out_opcode;
  logic [2:0]   out_funct3;
  logic         out_alt;
  logic         out_illegal;

  int n_tests = 0;
  int n_fail  = 0;

  id_stage #(.W(W), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .nrst(nrst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .radd1(radd1), .radd2(radd2), .rs1(rs1), .rs2(rs2),
    .wb_wen(wb_wen), .wb_wadd(wb_wadd), .wb_wdata(wb_wdata),
    .flush(flush), .ex_ready(ex_ready),
    .out_valid(out_valid), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data),
    .out_imm(out_imm), .out_rd(out_rd), .out_rd_we(out_rd_we),
    .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_alt(out_alt), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: registered read, read-before-write on the same edge.
  logic [W:0] rf_mem [32];
  always @(posedge clk) begin
    if (!nrst) begin
      for (int k = 0; k < 32; k++) rf_mem[k] <= '0;
      rs1 <= '0;
      rs2 <= '0;
    end else begin
      rs1 <= rf_mem[radd1];
      rs2 <= rf_mem[radd2];
      if (wb_wen) rf_mem[wb_wadd] <= wb_wdata;
    end
  end

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  ra1, ra2;
    logic [31:0] rs1_e, rs2_e, imm_e;
    logic [4:0]  rd_e;
    logic        we_e;
    logic [6:0]  opc_e;
    logic [2:0]  f3_e;
    logic        alt_e;
    logic        ill_e;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [W:0] pc);
    in_valid = v;
    in_instr = instr;
    in_pc    = pc;
  endtask

  task automatic wb(input logic en, input logic [4:0] addr, input logic [W:0] data);
    wb_wen   = en;
    wb_wadd  = addr;
    wb_wdata = data;
  endtask

  task automatic check_zero_bundle(input string tag);
    check({tag, "_valid"},   out_valid,    0);
    check({tag, "_pc"},      out_pc,       RESET_PC);
    check({tag, "_imm"},     out_imm,      0);
    check({tag, "_rd"},      out_rd,       0);
    check({tag, "_rd_we"},   out_rd_we,    0);
    check({tag, "_opcode"},  out_opcode,   0);
    check({tag, "_funct3"},  out_funct3,   0);
    check({tag, "_alt"},     out_alt,      0);
    check({tag, "_illegal"}, out_illegal,  0);
    check({tag, "_rs1"},     out_rs1_data, 0);
    check({tag, "_rs2"},     out_rs2_data, 0);
  endtask

  localparam logic [31:0] ADDI = 32'h0102_8313;  // addi x6,x5,16
  localparam logic [31:0] LUI  = 32'h1234_53B7;  // lui  x7,0x12345
  localparam logic [31:0] BEQ  = 32'hFE00_0EE3;  // beq  x0,x0,-4
  localparam logic [31:0] SW   = 32'hFE62_AC23;  // sw   x6,-8(x5)

  initial begin
    //            instr          ra1 ra2 rs1_e         rs2_e         imm_e         rd  we opc     f3 alt ill
    vecs[0]  = '{ADDI,          5,  16, 32'h1234,     32'h0,        32'h10,       6,  1, 7'h13, 0, 0, 0};
    vecs[1]  = '{LUI,           8,  3,  32'h88888888, 32'h3333,     32'h12345000, 7,  1, 7'h37, 5, 0, 0};
    vecs[2]  = '{SW,            5,  6,  32'h1234,     32'h6666,     32'hFFFFFFF8, 24, 0, 7'h23, 2, 1, 0};
    vecs[3]  = '{32'h008000EF,  0,  8,  32'h0,        32'h88888888, 32'h8,        1,  1, 7'h6F, 0, 0, 0};
    vecs[4]  = '{32'h406283B3,  5,  6,  32'h1234,     32'h6666,     32'h0,        7,  1, 7'h33, 0, 1, 0};
    vecs[5]  = '{32'h00432483,  6,  4,  32'h6666,     32'h0,        32'h4,        9,  1, 7'h03, 2, 0, 0};
    vecs[6]  = '{BEQ,           0,  0,  32'h0,        32'h0,        32'hFFFFFFFC, 29, 0, 7'h63, 0, 1, 0};
    vecs[7]  = '{32'h00000073,  0,  0,  32'h0,        32'h0,        32'h0,        0,  0, 7'h73, 0, 0, 0};
    vecs[8]  = '{32'h0000037F,  0,  0,  32'h0,        32'h0,        32'h0,        6,  0, 7'h7F, 0, 0, 1};
    vecs[9]  = '{32'h0000007F,  0,  0,  32'h0,        32'h0,        32'h0,        0,  0, 7'h7F, 0, 0, 1};
    vecs[10] = '{32'h00000312,  0,  0,  32'h0,        32'h0,        32'h0,        6,  0, 7'h12, 0, 0, 1};
    vecs[11] = '{32'hFFFFF517,  31, 31, 32'h0,        32'h0,        32'hFFFFF000, 10, 1, 7'h17, 7, 1, 0};
    vecs[12] = '{32'h0FF0000F,  0,  31, 32'h0,        32'h0,        32'h0,        0,  0, 7'h0F, 0, 0, 0};
    vecs[13] = '{32'h00C300E7,  6,  12, 32'h6666,     32'h0,        32'hC,        1,  1, 7'h67, 0, 0, 0};

    nrst = 1'b0; flush = 1'b0; ex_ready = 1'b1;
    drive(1'b0, 32'h0, '0);
    wb(1'b0, 5'd0, '0);

    // ---- reset state
    tick(); tick();
    check_zero_bundle("reset");
    check("reset_in_ready", in_ready, 1);
    nrst = 1'b1;

    // ---- preload register file through the write port
    wb(1'b1, 5'd5, 32'h1234);     tick();
    wb(1'b1, 5'd6, 32'h6666);     tick();
    wb(1'b1, 5'd8, 32'h88888888); tick();
    wb(1'b1, 5'd3, 32'h3333);     tick();
    wb(1'b0, 5'd0, '0);           tick();

    // ---- decode table, back-to-back at full throughput
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].instr, 32'h100 + 32'(4 * i));
      #1;
      check($sformatf("v%0d_radd1", i), radd1, vecs[i].ra1);
      check($sformatf("v%0d_radd2", i), radd2, vecs[i].ra2);
      tick();
      check($sformatf("v%0d_valid", i),   out_valid,    1);
      check($sformatf("v%0d_pc", i),      out_pc,       32'h100 + 32'(4 * i));
      check($sformatf("v%0d_rs1", i),     out_rs1_data, vecs[i].rs1_e);
      check($sformatf("v%0d_rs2", i),     out_rs2_data, vecs[i].rs2_e);
      check($sformatf("v%0d_imm", i),     out_imm,      vecs[i].imm_e);
      check($sformatf("v%0d_rd", i),      out_rd,       vecs[i].rd_e);
      check($sformatf("v%0d_rd_we", i),   out_rd_we,    vecs[i].we_e);
      check($sformatf("v%0d_opcode", i),  out_opcode,   vecs[i].opc_e);
      check($sformatf("v%0d_funct3", i),  out_funct3,   vecs[i].f3_e);
      check($sformatf("v%0d_alt", i),     out_alt,      vecs[i].alt_e);
      check($sformatf("v%0d_illegal", i), out_illegal,  vecs[i].ill_e);
    end
    drive(1'b0, 32'h0, '0);
    tick();
    check("drain_valid", out_valid, 0);

    // ---- registered bypass: write to x5 lands on the accept edge
    drive(1'b1, ADDI, 32'h200);
    wb(1'b1, 5'd5, 32'hDEAD);
    tick();
    drive(1'b0, 32'h0, '0);
    wb(1'b0, 5'd0, '0);
    #1;
    check("regbyp_valid", out_valid, 1);
    check("regbyp_rs1", out_rs1_data, 32'h0000DEAD);
    tick();
    wb(1'b1, 5'd5, 32'h1234); tick();
    wb(1'b0, 5'd0, '0);       tick();

    // ---- current-cycle bypass: write to x5 in the cycle after accept
    drive(1'b1, ADDI, 32'h210);
    tick();
    drive(1'b0, 32'h0, '0);
    #1;
    check("curbyp_before", out_rs1_data, 32'h1234);
    wb(1'b1, 5'd5, 32'hDEAD);
    #1;
    check("curbyp_rs1", out_rs1_data, 32'h0000DEAD);
    tick();
    wb(1'b1, 5'd5, 32'h1234); tick();
    wb(1'b0, 5'd0, '0);       tick();

    // ---- x0 operands stay zero while x0 is written
    drive(1'b1, BEQ, 32'h220);
    wb(1'b1, 5'd0, 32'h55);
    tick();
    drive(1'b0, 32'h0, '0);
    ex_ready = 1'b0;
    #1;
    check("x0_rs1", out_rs1_data, 0);
    check("x0_rs2", out_rs2_data, 0);
    check("x0_imm", out_imm, 32'hFFFFFFFC);
    check("x0_rd_we", out_rd_we, 0);
    tick();                                  // regfile now returns 0x55 for x0
    check("x0_rs1_reread", out_rs1_data, 0);
    check("x0_rs2_reread", out_rs2_data, 0);
    wb(1'b0, 5'd0, '0);
    ex_ready = 1'b1;
    tick();

    // ---- stall for 3 cycles, x5 written mid-stall, then no-bubble release
    drive(1'b1, ADDI, 32'h300);
    tick();
    ex_ready = 1'b0;
    drive(1'b1, LUI, 32'h304);
    #1;
    check("stall1_in_ready", in_ready, 0);
    check("stall1_radd1", radd1, 5);
    check("stall1_rs1", out_rs1_data, 32'h1234);
    tick();
    wb(1'b1, 5'd5, 32'h77);
    #1;
    check("stall2_pc", out_pc, 32'h300);
    check("stall2_rs1", out_rs1_data, 32'h77);
    tick();
    wb(1'b0, 5'd0, '0);
    #1;
    check("stall3_valid", out_valid, 1);
    check("stall3_pc", out_pc, 32'h300);
    check("stall3_rd", out_rd, 6);
    check("stall3_imm", out_imm, 32'h10);
    check("stall3_radd1", radd1, 5);
    check("stall3_rs1", out_rs1_data, 32'h77);
    tick();
    check("stall4_rs1", out_rs1_data, 32'h77);
    ex_ready = 1'b1;
    #1;
    check("release_in_ready", in_ready, 1);
    check("release_radd1", radd1, 8);
    tick();
    drive(1'b0, 32'h0, '0);
    check("release_valid", out_valid, 1);
    check("release_pc", out_pc, 32'h304);
    check("release_imm", out_imm, 32'h12345000);
    tick();
    check("release_drain", out_valid, 0);

    // ---- flush in the accept cycle discards the new instruction
    drive(1'b1, ADDI, 32'h400);
    tick();
    drive(1'b1, SW, 32'h404);
    flush = 1'b1;
    #1;
    check("flush_acc_in_ready", in_ready, 1);
    tick();
    flush = 1'b0;
    drive(1'b0, 32'h0, '0);
    check("flush_acc_valid", out_valid, 0);

    // ---- flush during a stall
    drive(1'b1, ADDI, 32'h410);
    tick();
    ex_ready = 1'b0;
    drive(1'b1, LUI, 32'h414);
    flush = 1'b1;
    #1;
    check("flush_stall_in_ready", in_ready, 0);
    tick();
    flush = 1'b0;
    check("flush_stall_valid", out_valid, 0);
    check("flush_stall_in_ready2", in_ready, 1);
    tick();                                  // LUI accepted now
    ex_ready = 1'b1;
    drive(1'b0, 32'h0, '0);
    check("after_flush_valid", out_valid, 1);
    check("after_flush_pc", out_pc, 32'h414);
    tick();

    // ---- reset while a bundle is held
    drive(1'b1, ADDI, 32'h500);
    tick();
    check("pre_reset_valid", out_valid, 1);
    nrst = 1'b0;
    tick();
    check_zero_bundle("midreset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
